charge_detect: RTL and testbench
================================

# charge_detect

Tone receiver for the piezo fanfare path. It takes a single-ended square wave from the piezo drive net or a test microphone comparator and measures the period between rising edges. It classifies each period as one of the four fanfare notes (G6, C7, E7, G7), reports stable notes, and pulses `charge_det` when the complete charge fanfare G6-C7-E7-G7-E7-G7 has been heard. It sits beside the tone generator, closing the loop for self-test and for a second board listening to the first.

## Interface
- FAST_SIM, 1, nonzero: period counter advances by 15 per clk, matching the generator's simulation speed-up. 0: advances by 1.
- MIN_PERIODS, 4: consecutive in-window periods needed to declare a stable note (range 1–15).
- TIMEOUT, 65536: period-count value at or above which the input is treated as silence.
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- tone_in, input, 1: asynchronous square wave to be decoded.
- note, output, 3: current stable note. 0 = none, 1 = G6, 2 = C7, 3 = E7, 4 = G7.
- note_vld, output, 1: one-cycle pulse when `note` changes to a new nonzero stable value.
- charge_det, output, 1: one-cycle pulse when the full fanfare sequence has been recognised.

## Operation
- **Input conditioning.** `tone_in` passes through a 2-flop synchroniser. A rising edge is detected as sync2 high and a third flop low; call this the "edge cycle".
- **Period counter `cnt`.**
  - 17-bit, STEP = 15 if FAST_SIM, else 1.
  - Non-edge cycle: `cnt` += STEP, saturating at 0x1FFFF.
  - Edge cycle: `meas` <= `cnt`, `cnt` <= STEP.
  - The first edge after reset or silence only restarts `cnt`. Its `meas` is discarded via a `primed` flag.
- **Classification.** Nominal periods: G6 31888, C7 23900, E7 18961, G7 15944. A period matches note N if |meas − N| ≤ N>>5. Windows do not overlap. No match gives class 0.
- **Run tracking.**
  - A valid `meas` with the same nonzero class as the previous one increments the 4-bit run counter, saturating at MIN_PERIODS.
  - A different nonzero class sets the run counter to 1.
  - Class 0 clears the run counter and leaves `note` unchanged.
- **Stable-note declaration.** When the run reaches MIN_PERIODS and the class differs from `note`:
  - `note` <= class
  - `note_vld` pulses once.
  - Reaching MIN_PERIODS again for the same note does not re-pulse.
- **Silence.** When `cnt` ≥ TIMEOUT:
  - `note` <= 0
  - run counter <= 0
  - `primed` <= 0
  - sequence FSM <= IDLE
  - No `note_vld` pulse.
- **Sequence FSM.**
  - States: IDLE, S_G6, S_C7, S_E7A, S_G7A, S_E7B.
  - The FSM advances only on `note_vld`: IDLE→S_G6 on G6, S_G6→S_C7 on C7, S_C7→S_E7A on E7, S_E7A→S_G7A on G7, S_G7A→S_E7B on E7.
  - In S_E7B, G7 pulses `charge_det` and returns the FSM to IDLE.
  - Any other `note_vld` value goes to S_G6 if it is G6, otherwise to IDLE.
- **Reset values.** `note` = 0, `note_vld` = 0, `charge_det` = 0, FSM = IDLE, `cnt` = 0, `meas` = 0, run counter = 0, `primed` = 0.
- **Reset mid-tone.** Asserting reset mid-tone discards all progress. Decoding restarts from the next rising edge after deassertion.

## Timing
- The edge cycle occurs 3 clk edges after the first clk edge that samples `tone_in` high.
- `meas` is registered at the end of the edge cycle. Classification and the run update occur in edge+1.
- `note` and `note_vld` are registered and change/assert in edge+2.
- `charge_det` is registered and asserts the cycle after the final `note_vld` (edge+3).
- Silence takes effect the cycle after `cnt` first reaches ≥ TIMEOUT.
- Simultaneous edge cycle and `cnt` ≥ TIMEOUT: silence wins. The edge only restarts `cnt`, and `primed` is set.
- Decodable periods are 15446..32884 counter units. Sub-window glitches classify as 0 and break the run.

## Test plan
- **Single note.** FAST_SIM=0, MIN_PERIODS=4, square wave with 23900-cycle period, 50% duty. Required: `note_vld` pulses exactly once, 2 cycles after the 5th rising edge, with `note` = 2. No further pulses over 20 periods.
- **Tolerance boundary.** Period 15944+498 → `note` = 4. Period 15944+499 → class 0, run never builds, `note` stays 0.
- **Full fanfare.** Drive the generator with FAST_SIM=1 and `go` pulsed into this block with FAST_SIM=1. Required: `note_vld` with values 1,2,3,4,3,4 in order, then a single `charge_det` pulse. `note` returns to 0 after TIMEOUT of silence.
- **Broken sequence.** G6, C7, G7 (E7 skipped). Required: FSM goes to IDLE, no `charge_det`. A following full correct sequence produces `charge_det`.
- **Silence and restart.** A 70000-cycle low gap mid-sequence. Required: `note` = 0 at `cnt` = 65536 with no `note_vld`, and the FSM returns to IDLE. The first edge after the gap produces no measurement.
- **Reset mid-run.** Assert `rst` for 3 cycles after 3 C7 periods. Required: all outputs are 0 during reset, and `note_vld` occurs only after 5 further rising edges.

Source files
------------

// File: rtl/charge_detect.sv
// charge_detect: measures the period of an incoming square wave, classifies it
// as one of the four fanfare notes, reports stable notes and flags the full
// G6-C7-E7-G7-E7-G7 charge fanfare.
module charge_detect #(
  parameter int unsigned FAST_SIM    = 1,
  parameter int unsigned MIN_PERIODS = 4,
  parameter int unsigned TIMEOUT     = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  output logic [2:0] note,
  output logic       note_vld,
  output logic       charge_det
);

  localparam int unsigned CNT_W = 17;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned RUN_W = 4;
  localparam int unsigned STEP  = (FAST_SIM != 0) ? 15 : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEP);
  localparam logic [RUN_W-1:0] RUN_MIN  = RUN_W'(MIN_PERIODS);

  localparam int unsigned NOM_G6 = 31888;
  localparam int unsigned NOM_C7 = 23900;
  localparam int unsigned NOM_E7 = 18961;
  localparam int unsigned NOM_G7 = 15944;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_G6   = 3'd1;
  localparam logic [2:0] NOTE_C7   = 3'd2;
  localparam logic [2:0] NOTE_E7   = 3'd3;
  localparam logic [2:0] NOTE_G7   = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    S_G6,
    S_C7,
    S_E7A,
    S_G7A,
    S_E7B
  } seq_state_e;

  // True when m lies within nom +/- nom/32.
  function automatic logic in_window(input logic [CNT_W-1:0] m, input int unsigned nom);
    int unsigned mv;
    int unsigned tol;
    mv  = 32'(m);
    tol = nom >> 5;
    return (mv + tol >= nom) && (mv <= nom + tol);
  endfunction

  // Map a measured period onto a note code; windows are disjoint.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] m);
    logic [2:0] c;
    c = NOTE_NONE;
    if (in_window(m, NOM_G6))      c = NOTE_G6;
    else if (in_window(m, NOM_C7)) c = NOTE_C7;
    else if (in_window(m, NOM_E7)) c = NOTE_E7;
    else if (in_window(m, NOM_G7)) c = NOTE_G7;
    return c;
  endfunction

  logic             sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             meas_vld_q, meas_vld_d;
  logic             primed_q, primed_d;
  logic [2:0]       last_cls_q, last_cls_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       note_q, note_d;
  logic             note_vld_q, note_vld_d;
  seq_state_e       state_q, state_d;
  logic             charge_q, charge_d;

  logic             edge_c;
  logic             silence_c;
  logic [SUM_W-1:0] cnt_sum_c;
  logic [2:0]       cls_c;

  assign edge_c     = sync2_q & ~sync3_q;
  assign silence_c  = 32'(cnt_q) >= TIMEOUT;
  assign cls_c      = classify(meas_q);

  assign note       = note_q;
  assign note_vld   = note_vld_q;
  assign charge_det = charge_q;

  // Period counter: restart on each rising edge, capture the elapsed count.
  always_comb begin
    cnt_sum_c  = {1'b0, cnt_q} + SUM_W'(STEP);
    cnt_d      = cnt_sum_c[CNT_W] ? CNT_MAX : cnt_sum_c[CNT_W-1:0];
    meas_d     = meas_q;
    meas_vld_d = 1'b0;
    primed_d   = primed_q;
    if (edge_c) begin
      cnt_d      = CNT_STEP;
      meas_d     = cnt_q;
      meas_vld_d = primed_q & ~silence_c;
      primed_d   = 1'b1;
    end else if (silence_c) begin
      primed_d   = 1'b0;
    end
  end

  // Run tracking and stable-note declaration; silence clears everything.
  always_comb begin
    run_d      = run_q;
    last_cls_d = last_cls_q;
    note_d     = note_q;
    note_vld_d = 1'b0;
    if (silence_c) begin
      run_d      = '0;
      last_cls_d = NOTE_NONE;
      note_d     = NOTE_NONE;
    end else if (meas_vld_q) begin
      last_cls_d = cls_c;
      if (cls_c == NOTE_NONE)        run_d = '0;
      else if (cls_c == last_cls_q)  run_d = (run_q >= RUN_MIN) ? RUN_MIN : run_q + RUN_W'(1);
      else                           run_d = RUN_W'(1);
      if ((run_d == RUN_MIN) && (cls_c != note_q) && (cls_c != NOTE_NONE)) begin
        note_d     = cls_c;
        note_vld_d = 1'b1;
      end
    end
  end

  // Fanfare sequencer: advances only on freshly declared notes.
  always_comb begin
    state_d  = state_q;
    charge_d = 1'b0;
    if (silence_c) begin
      state_d = IDLE;
    end else if (note_vld_q) begin
      state_d = (note_q == NOTE_G6) ? S_G6 : IDLE;
      case (state_q)
        S_G6:  if (note_q == NOTE_C7) state_d = S_C7;
        S_C7:  if (note_q == NOTE_E7) state_d = S_E7A;
        S_E7A: if (note_q == NOTE_G7) state_d = S_G7A;
        S_G7A: if (note_q == NOTE_E7) state_d = S_E7B;
        S_E7B: begin
          if (note_q == NOTE_G7) begin
            state_d  = IDLE;
            charge_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Synchroniser, edge-detect flop and period measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      cnt_q      <= '0;
      meas_q     <= '0;
      meas_vld_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      sync1_q    <= tone_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      cnt_q      <= cnt_d;
      meas_q     <= meas_d;
      meas_vld_q <= meas_vld_d;
      primed_q   <= primed_d;
    end
  end

  // Decoder state: run length, last class and reported note.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= '0;
      last_cls_q <= NOTE_NONE;
      note_q     <= NOTE_NONE;
      note_vld_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      last_cls_q <= last_cls_d;
      note_q     <= note_d;
      note_vld_q <= note_vld_d;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      charge_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      charge_q <= charge_d;
    end
  end

endmodule

// File: tb/tb_charge_detect.sv
// tb_charge_detect: directed tone patterns with a scoreboard of expected
// note_vld / charge_det events (value and cycle).
module tb_charge_detect;

  localparam int MIN_P = 2;
  localparam int TMO   = 34000;
  // Periods in clocks; with FAST_SIM the counter advances 15 per clock.
  localparam int PG6 = 2126;   // 31890
  localparam int PC7 = 1593;   // 23895
  localparam int PE7 = 1264;   // 18960
  localparam int PG7 = 1063;   // 15945
  localparam int GAP = 2200;
  // Cycles from a rise (driven at negedge with cyc=k) to the silence cycle.
  localparam int SIL = 2 + (TMO + 14) / 15;
  localparam int CODE_CHG = 8;

  logic       clk;
  logic       rst;
  logic       tone_in;
  logic [2:0] note;
  logic       note_vld;
  logic       charge_det;

  typedef struct {
    int ecode;
    int ecyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   last_rise = 0;

  charge_detect #(
    .FAST_SIM(1),
    .MIN_PERIODS(MIN_P),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tone_in(tone_in),
    .note(note),
    .note_vld(note_vld),
    .charge_det(charge_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic pop_cmp(input string what, input int code);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s unexpected: got %0d at cycle %0d, expected no event", what, code, cyc);
    end else begin
      e = exp_q.pop_front();
      check({what, " value"}, code, e.ecode);
      check({what, " cycle"}, cyc, e.ecyc);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (note_vld)   pop_cmp("note_vld", int'(note));
      if (charge_det) pop_cmp("charge_det", CODE_CHG);
    end
  end

  // n periods of p clocks; on rise idx expect note_vld=code (and charge if chg).
  task automatic play(input int p, input int n, input int idx, input int code, input bit chg);
    for (int i = 0; i < n; i++) begin
      tone_in   = 1'b1;
      last_rise = cyc;
      if (i == idx) begin
        exp_q.push_back('{code, cyc + 4});
        if (chg) exp_q.push_back('{CODE_CHG, cyc + 5});
      end
      repeat (p / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic quiet(input int n);
    tone_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " note"}, int'(note), 0);
    check({tag, " note_vld"}, int'(note_vld), 0);
    check({tag, " charge_det"}, int'(charge_det), 0);
  endtask

  initial begin
    int k;
    rst     = 1'b1;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single note: prime, run 1, declare on 3rd rise, then no re-pulse.
    play(PG7, 6, 2, 4, 1'b0);
    check("single note", int'(note), 4);
    quiet(GAP);
    check("single note silence", int'(note), 0);

    // Tolerance: 16440 inside G7 window; 16455 and 15435 outside.
    play(1096, 3, 2, 4, 1'b0);
    check("g7 upper edge", int'(note), 4);
    quiet(GAP);
    play(1097, 3, -1, 0, 1'b0);
    play(1029, 3, -1, 0, 1'b0);
    check("outside window", int'(note), 0);
    quiet(GAP);

    // Broken G6-C7-G7, then full fanfare; each note declared on the next note's first rise.
    play(PG6, 2, -1, 0, 1'b0);
    play(PC7, 2, 0, 1, 1'b0);
    play(PG7, 2, 0, 2, 1'b0);
    play(PG6, 2, 0, 4, 1'b0);
    play(PC7, 2, 0, 1, 1'b0);
    play(PE7, 2, 0, 2, 1'b0);
    play(PG7, 2, 0, 3, 1'b0);
    play(PE7, 2, 0, 4, 1'b0);
    play(PG7, 2, 0, 3, 1'b0);
    play(PG7, 1, 0, 4, 1'b1);
    quiet(GAP);
    check("fanfare silence", int'(note), 0);

    // Silence mid-sequence: note clears exactly one cycle after timeout, FSM back to IDLE.
    play(PG6, 2, -1, 0, 1'b0);
    play(PC7, 2, 0, 1, 1'b0);
    play(PC7, 1, 0, 2, 1'b0);
    k = last_rise;
    while (cyc < k + SIL) @(negedge clk);
    check("note before timeout", int'(note), 2);
    @(negedge clk);
    check("note at timeout", int'(note), 0);
    quiet(200);
    play(PE7, 2, -1, 0, 1'b0);
    play(PG7, 2, 0, 3, 1'b0);
    play(PE7, 2, 0, 4, 1'b0);
    play(PG7, 2, 0, 3, 1'b0);
    play(PG7, 1, 0, 4, 1'b0);
    quiet(GAP);

    // Reset mid-run: progress discarded, decoding restarts after release.
    play(PG7, 2, -1, 0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("mid reset");
    end
    rst = 1'b0;
    play(PG7, 4, 2, 4, 1'b0);
    quiet(20);

    check("pending events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
